// File: rtl/matmul_calc_pkg.sv
// Shared types for the APB command master: command/response structs, FSM states, bus widths.
// No logic of its own.
package matmul_calc_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int MAX_DIM    = 4;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]  wdata;
    logic [MAX_DIM-1:0]    strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] rdata;
    logic                 slverr;
    logic                 timeout;
  } apb_rsp_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue: registered output, no bypass, so a push is visible one cycle later.
// Flush empties it at the next edge and drops a same-cycle push; full is flagged at DEPTH entries.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/matmul_apb_master.sv
// APB requester fed from a command FIFO; minimum 4 cycles per transaction (pop, SETUP, ACCESS, RESP).
// cmd_ready_o follows FIFO not-full; RESP holds until rsp_ready_i; ACCESS is bounded by TIMEOUT cycles.
module matmul_apb_master
  import matmul_calc_pkg::*;
#(
  parameter int BUS_WIDTH  = matmul_calc_pkg::BUS_WIDTH,
  parameter int ADDR_WIDTH = matmul_calc_pkg::ADDR_WIDTH,
  parameter int MAX_DIM    = matmul_calc_pkg::MAX_DIM,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  apb_cmd_t              cmd_i,
  input  logic                  flush_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output apb_rsp_t              rsp_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic                  busy_o,
  output logic [15:0]           txn_count_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CMD_DEPTH) + 1;

  apb_state_e             state_q, state_d;
  apb_cmd_t               hold_q, hold_d;
  apb_rsp_t               rsp_q, rsp_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [15:0]            txn_q, txn_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$bits(apb_cmd_t)-1:0] fifo_dout;
  logic [CW-1:0]          fifo_count;

  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;

  apb_cmd_fifo #(
    .WIDTH ($bits(apb_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .din_i   (cmd_i),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rsp_d    = rsp_q;
    tmo_d    = tmo_q;
    txn_d    = txn_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = apb_cmd_t'(fifo_dout);
          state_d  = SETUP;
        end
      end
      SETUP: begin
        tmo_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rsp_d.rdata   = hold_q.write ? '0 : prdata_i;
          rsp_d.slverr  = pslverr_i;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Slave never answered: synthesise an error response and release the bus.
          rsp_d.rdata   = '0;
          rsp_d.slverr  = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          txn_d   = txn_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rsp_q   <= '0;
      tmo_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rsp_q   <= rsp_d;
      tmo_q   <= tmo_d;
      txn_q   <= txn_d;
    end
  end

  // Bus outputs decode straight from flops so reset drops psel/penable without a clock.
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign pwrite_o    = hold_q.write;
  assign paddr_o     = hold_q.addr;
  assign pwdata_o    = hold_q.wdata;
  assign pstrb_o     = hold_q.write ? hold_q.strb : '0;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_o       = rsp_q;
  assign busy_o      = (state_q != IDLE) || (fifo_count != '0);
  assign txn_count_o = txn_q;

endmodule
